// File: rtl/wb_multi_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_multi_timer_pkg
// Description : Shared register map, CTRL/STATUS bit positions, address
//               field slices and the byte-lane merge helper for the
//               Wishbone multi-channel timer.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_multi_timer_pkg;

    // Byte offsets of the per-channel registers inside a 16-byte window
    localparam logic [3:0] OFF_COUNT  = 4'h0;
    localparam logic [3:0] OFF_RELOAD = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    // Word-select view of the same offsets (address bits [3:2])
    typedef enum logic [1:0] {
        REG_COUNT  = OFF_COUNT[3:2],
        REG_RELOAD = OFF_RELOAD[3:2],
        REG_CTRL   = OFF_CTRL[3:2],
        REG_STATUS = OFF_STATUS[3:2]
    } reg_sel_e;

    // CTRL / STATUS bit indices
    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_IRQ_EN_BIT   = 1;
    localparam int CTRL_PERIODIC_BIT = 2;
    localparam int STATUS_FLAG_BIT   = 0;

    // Address field slices
    localparam int REG_LSB  = 2;
    localparam int REG_MSB  = 3;
    localparam int CH_LSB   = 4;
    localparam int CH_MSB   = 6;
    localparam int CH_HI    = 7;   // set => beyond the 8-channel window
    localparam int PAGE_LSB = 8;   // base compare covers [31:PAGE_LSB]

    // Replace only the byte lanes whose select bit is set
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage : wb_multi_timer_pkg
`default_nettype wire

// File: rtl/wb_timer_channel.sv
`default_nettype none
// ============================================================================
// Module      : wb_timer_channel
// Description : One down-counting timer: COUNT, RELOAD, CTRL (en, irq_en,
//               periodic), sticky expiry flag and a toggle output.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timer_channel
    import wb_multi_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             wr_count,
    input  logic             wr_reload,
    input  logic             wr_ctrl,     // already qualified with byte lane 0
    input  logic             wr_status,   // already qualified with byte lane 0
    input  logic [31:0]      wdata,
    input  logic [3:0]       wsel,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] reload,
    output logic             en,
    output logic             irq_en,
    output logic             periodic,
    output logic             flag,
    output logic             toggle
);

    logic        tick;
    logic        expire;
    logic [31:0] count_wr;
    logic [31:0] reload_wr;
    logic        unused_merge;

    assign tick      = en & ~freeze;
    assign expire    = tick & (count == '0);
    assign count_wr  = byte_merge(32'(count), wdata, wsel);
    assign reload_wr = byte_merge(32'(reload), wdata, wsel);
    assign unused_merge = ^{count_wr, reload_wr};

    // Counter: a bus write overrides this cycle's tick; expiry reloads or parks at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_count) begin
            count <= count_wr[CNT_W-1:0];
        end else if (tick) begin
            if (count != '0) begin
                count <= count - 1'b1;
            end else if (periodic) begin
                count <= reload;
            end
        end
    end

    // Reload value register
    always_ff @(posedge clk) begin
        if (rst) begin
            reload <= '0;
        end else if (wr_reload) begin
            reload <= reload_wr[CNT_W-1:0];
        end
    end

    // Control bits: a CTRL write takes priority over the one-shot self-disable
    always_ff @(posedge clk) begin
        if (rst) begin
            en       <= 1'b0;
            irq_en   <= 1'b0;
            periodic <= 1'b0;
        end else if (wr_ctrl) begin
            en       <= wdata[CTRL_EN_BIT];
            irq_en   <= wdata[CTRL_IRQ_EN_BIT];
            periodic <= wdata[CTRL_PERIODIC_BIT];
        end else if (expire && !periodic) begin
            en <= 1'b0;
        end
    end

    // Sticky flag (set beats W1C) and toggle output inverted on every expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            flag   <= 1'b0;
            toggle <= 1'b0;
        end else begin
            if (expire) begin
                flag   <= 1'b1;
                toggle <= ~toggle;
            end else if (wr_status && wdata[STATUS_FLAG_BIT]) begin
                flag <= 1'b0;
            end
        end
    end

endmodule : wb_timer_channel
`default_nettype wire

// File: rtl/wb_multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : wb_multi_timer
// Description : NUM_CH independent down-counting timers behind the Caravel
//               Wishbone slave port. Drives user_irq[0] and per-channel
//               toggle pads. Optional build macro LA_OVERRIDE_EN enables
//               logic-analyzer channel freeze and observation.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module wb_multi_timer
    import wb_multi_timer_pkg::*;
#(
    parameter int          NUM_CH   = 4,
    parameter int          CNT_W    = 32,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          IO_BASE  = 8
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    output logic                       wbs_ack_o,
    output logic [31:0]                wbs_dat_o,
    input  logic [127:0]               la_data_in,
    input  logic [127:0]               la_oenb,
    output logic [127:0]               la_data_out,
    input  logic [`MPRJ_IO_PADS-1:0]   io_in,
    output logic [`MPRJ_IO_PADS-1:0]   io_out,
    output logic [`MPRJ_IO_PADS-1:0]   io_oeb,
    output logic [2:0]                 user_irq
);

    localparam int PADS = `MPRJ_IO_PADS;

    logic             hit;
    logic             req;
    logic             wr_req;
    logic             ch_valid;
    logic [2:0]       ch_idx;
    reg_sel_e         reg_sel;
    logic [31:0]      rdata;
    logic             unused_inputs;

    logic [CNT_W-1:0] count_q  [NUM_CH];
    logic [CNT_W-1:0] reload_q [NUM_CH];
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] irq_en_q;
    logic [NUM_CH-1:0] periodic_q;
    logic [NUM_CH-1:0] flag_q;
    logic [NUM_CH-1:0] toggle_q;

    // Address decode: page hit, channel index, register word
    assign hit      = (wbs_adr_i[31:PAGE_LSB] == BASE_ADR[31:PAGE_LSB]);
    assign req      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & hit;
    assign ch_idx   = wbs_adr_i[CH_MSB:CH_LSB];
    assign ch_valid = ~wbs_adr_i[CH_HI] & ({1'b0, ch_idx} < 4'(NUM_CH));
    assign reg_sel  = reg_sel_e'(wbs_adr_i[REG_MSB:REG_LSB]);
    assign wr_req   = req & wbs_we_i & ch_valid;

    assign unused_inputs = ^{io_in, la_data_in, la_oenb, wbs_adr_i[1:0]};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic sel_ch;
        logic frz;

        assign sel_ch = wr_req & (ch_idx == 3'(c));
`ifdef LA_OVERRIDE_EN
        assign frz = ~la_oenb[c] & la_data_in[c];
`else
        assign frz = 1'b0;
`endif

        wb_timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (wb_clk_i),
            .rst       (wb_rst_i),
            .freeze    (frz),
            .wr_count  (sel_ch & (reg_sel == REG_COUNT)),
            .wr_reload (sel_ch & (reg_sel == REG_RELOAD)),
            .wr_ctrl   (sel_ch & (reg_sel == REG_CTRL)   & wbs_sel_i[0]),
            .wr_status (sel_ch & (reg_sel == REG_STATUS) & wbs_sel_i[0]),
            .wdata     (wbs_dat_i),
            .wsel      (wbs_sel_i),
            .count     (count_q[c]),
            .reload    (reload_q[c]),
            .en        (en_q[c]),
            .irq_en    (irq_en_q[c]),
            .periodic  (periodic_q[c]),
            .flag      (flag_q[c]),
            .toggle    (toggle_q[c])
        );
    end

    // Read mux: unmapped channels and the upper window read as zero
    always_comb begin
        rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_valid && (ch_idx == 3'(c))) begin
                case (reg_sel)
                    REG_COUNT:  rdata = 32'(count_q[c]);
                    REG_RELOAD: rdata = 32'(reload_q[c]);
                    REG_CTRL: begin
                        rdata[CTRL_EN_BIT]       = en_q[c];
                        rdata[CTRL_IRQ_EN_BIT]   = irq_en_q[c];
                        rdata[CTRL_PERIODIC_BIT] = periodic_q[c];
                    end
                    REG_STATUS: rdata[STATUS_FLAG_BIT] = flag_q[c];
                    default:    rdata = '0;
                endcase
            end
        end
    end

    // Single-cycle ack one clock after the request; data registered with it
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= req ? rdata : '0;
        end
    end

    assign user_irq = {2'b00, |(flag_q & irq_en_q)};

    // Toggle pads sit at IO_BASE..IO_BASE+NUM_CH-1; every other pad is an input
    assign io_out = {{(PADS-NUM_CH){1'b0}}, toggle_q} << IO_BASE;
    assign io_oeb = ~({{(PADS-NUM_CH){1'b0}}, {NUM_CH{1'b1}}} << IO_BASE);

`ifdef LA_OVERRIDE_EN
    // LA observation: channel 0 count in the low word, flags from bit 64
    always_comb begin
        la_data_out                 = '0;
        la_data_out[CNT_W-1:0]      = count_q[0];
        la_data_out[64 +: NUM_CH]   = flag_q;
    end
`else
    assign la_data_out = '0;
`endif

endmodule : wb_multi_timer
`default_nettype wire

// File: tb/tb_wb_multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_multi_timer
// Description : Self-checking bench for wb_multi_timer: directed scenarios
//               with literal expectations plus randomized bus traffic checked
//               every cycle against a behavioural timer model.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module tb_wb_multi_timer;

    localparam int          NC      = 4;
    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam int          IOB     = 8;
    localparam int          PADS    = `MPRJ_IO_PADS;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]          sel = 4'h0;
    logic [31:0]         adr = '0, dat = '0;
    logic [127:0]        la_in = '0, la_oenb = '1;
    logic [PADS-1:0]     io_in = '0;
    logic                wbs_ack_o;
    logic [31:0]         wbs_dat_o;
    logic [127:0]        la_data_out;
    logic [PADS-1:0]     io_out, io_oeb;
    logic [2:0]          user_irq;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    wb_multi_timer #(
        .NUM_CH(NC), .CNT_W(32), .BASE_ADR(BASE), .IO_BASE(IOB)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .la_data_in(la_in), .la_oenb(la_oenb), .la_data_out(la_data_out),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .user_irq(user_irq)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_cnt [NC];
    logic [31:0] m_rel [NC];
    bit m_en [NC], m_irq [NC], m_per [NC], m_flag [NC], m_tog [NC];
    bit          m_ack = 1'b0;
    logic [31:0] m_dat = '0;

    function automatic bit frozen(input int c);
`ifdef LA_OVERRIDE_EN
        return !la_oenb[c] && la_in[c];
`else
        return (c < 0);
`endif
    endfunction

    task automatic model_step();
        bit          req, valid;
        bit          expired [NC];
        int          ch, rg;
        logic [31:0] rd, mask, cnt0, rel0;
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                m_cnt[c] = 0; m_rel[c] = 0; m_en[c] = 0; m_irq[c] = 0;
                m_per[c] = 0; m_flag[c] = 0; m_tog[c] = 0;
            end
            m_ack = 0; m_dat = 0;
            return;
        end
        req   = cyc && stb && !m_ack && (adr[31:8] == BASE[31:8]);
        ch    = int'(adr[7:4]);
        rg    = int'(adr[3:2]);
        valid = (ch < NC);
        rd = 0; cnt0 = 0; rel0 = 0;
        if (valid) begin
            cnt0 = m_cnt[ch];
            rel0 = m_rel[ch];
            case (rg)
                0: rd = m_cnt[ch];
                1: rd = m_rel[ch];
                2: rd = 32'(m_en[ch]) + 32'(m_irq[ch]) * 2 + 32'(m_per[ch]) * 4;
                default: rd = 32'(m_flag[ch]);
            endcase
        end
        // every enabled, unfrozen timer advances one step
        for (int c = 0; c < NC; c++) begin
            expired[c] = 0;
            if (m_en[c] && !frozen(c)) begin
                if (m_cnt[c] != 0) m_cnt[c] = m_cnt[c] - 1;
                else begin
                    expired[c] = 1;
                    m_flag[c]  = 1;
                    m_tog[c]   = !m_tog[c];
                    if (m_per[c]) m_cnt[c] = m_rel[c];
                    else          m_en[c]  = 0;
                end
            end
        end
        // then the bus write is layered on top
        if (req && we && valid) begin
            mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            case (rg)
                0: m_cnt[ch] = (cnt0 & ~mask) | (dat & mask);
                1: m_rel[ch] = (rel0 & ~mask) | (dat & mask);
                2: if (sel[0]) begin
                       m_en[ch] = dat[0]; m_irq[ch] = dat[1]; m_per[ch] = dat[2];
                   end
                default: if (sel[0] && dat[0] && !expired[ch]) m_flag[ch] = 0;
            endcase
        end
        m_ack = req;
        m_dat = req ? rd : 32'h0;
    endtask

    always @(posedge clk) model_step();

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [PADS-1:0] e_io, e_oeb;
        logic [127:0]    e_la;
        bit              e_irq;
        if (chk_on) begin
            e_io = '0; e_oeb = '1; e_la = '0; e_irq = 0;
            for (int c = 0; c < NC; c++) begin
                e_io[IOB + c]  = m_tog[c];
                e_oeb[IOB + c] = 1'b0;
                if (m_flag[c] && m_irq[c]) e_irq = 1;
`ifdef LA_OVERRIDE_EN
                e_la[64 + c] = m_flag[c];
`endif
            end
`ifdef LA_OVERRIDE_EN
            e_la[31:0] = m_cnt[0];
`endif
            check("ack", 128'(wbs_ack_o), 128'(m_ack));
            if (m_ack) check("rdata", 128'(wbs_dat_o), 128'(m_dat));
            check("user_irq", 128'(user_irq), 128'({2'b00, e_irq}));
            check("io_out", 128'(io_out), 128'(e_io));
            check("io_oeb", 128'(io_oeb), 128'(e_oeb));
            check("la_data_out", la_data_out, e_la);
        end
    end

    // ---------------- bus helpers (called at a negedge, return at a negedge) ----
    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rdv, output int lat);
        cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
        lat = 0; rdv = '0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin
                lat = i; rdv = wbs_dat_o;
                break;
            end
        end
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r; int l;
        xfer(1'b1, a, d, 4'hF, r, l);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v, output int l);
        xfer(1'b0, a, 32'h0, 4'hF, v, l);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int          l, first, k;
        bit          prev, cur;
        int          tg[$];
        int          ch, rg;
        logic [31:0] a, d;
        logic [3:0]  s;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk_on = 1;

        // 1: reset state of every register, ack one cycle after strobe
        for (int c = 0; c < NC; c++) begin
            for (int r = 0; r < 4; r++) begin
                idle(1);
                rd(BASE + 32'(c * 16 + r * 4), v, l);
                check("t1_lat", 128'(l), 128'(1));
                check("t1_val", 128'(v), 128'(0));
            end
        end

        // 2: ch0 periodic RELOAD=3 COUNT=3 -> toggles 4, 8, 12 cycles after enable
        wr(BASE + 32'h04, 32'd3);
        wr(BASE + 32'h00, 32'd3);
        wr(BASE + 32'h08, 32'h5);
        prev = io_out[IOB];
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            cur = io_out[IOB];
            if (cur != prev) tg.push_back(i);
            prev = cur;
        end
        @(negedge clk);
        check("t2_ntoggles", 128'(tg.size()), 128'(3));
        for (int i = 0; i < 3; i++)
            check("t2_toggle_cycle", 128'(i < tg.size() ? tg[i] : -1), 128'(4 * (i + 1)));
        rd(BASE + 32'h0C, v, l);
        check("t2_flag", 128'(v), 128'(1));

        // 3: ch1 one-shot COUNT=2 with irq -> flag/irq at cycle 3, en self-clears
        wr(BASE + 32'h10, 32'd2);
        wr(BASE + 32'h18, 32'h3);
        first = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (user_irq[0] && first == 0) first = i;
        end
        @(negedge clk);
        check("t3_irq_cycle", 128'(first), 128'(3));
        rd(BASE + 32'h18, v, l);
        check("t3_ctrl", 128'(v), 128'(2));
        check("t3_irq_held", 128'(user_irq[0]), 128'(1));
        wr(BASE + 32'h1C, 32'h1);
        check("t3_irq_clear", 128'(user_irq[0]), 128'(0));

        // 4: W1C during expiry keeps the flag; COUNT write during tick wins
        wr(BASE + 32'h24, 32'd0);
        wr(BASE + 32'h20, 32'd0);
        wr(BASE + 32'h28, 32'h5);       // expires every cycle from now on
        wr(BASE + 32'h2C, 32'h1);
        rd(BASE + 32'h2C, v, l);
        check("t4_flag_set_wins", 128'(v), 128'(1));
        wr(BASE + 32'h30, 32'd100);
        wr(BASE + 32'h38, 32'h1);
        wr(BASE + 32'h30, 32'h1234);
        // the read is sampled two edges after the write (ack cycle blocks it): one tick
        rd(BASE + 32'h30, v, l);
        check("t4_count_write_wins", 128'(v), 128'(32'h1233));

        // 5: unmapped channel, upper window and wrong base
        idle(1);
        xfer(1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, v, l);
        check("t5_oob_wr_ack", 128'(l), 128'(1));
        rd(BASE + 32'h40, v, l);
        check("t5_oob_rd", 128'(v), 128'(0));
        wr(BASE + 32'h88, 32'h0);
        rd(BASE + 32'h88, v, l);
        check("t5_hi_rd", 128'(v), 128'(0));
        rd(BASE + 32'h08, v, l);
        check("t5_ch0_ctrl_kept", 128'(v), 128'(5));
        rd(32'h3000_0108, v, l);
        check("t5_badbase_noack", 128'(l), 128'(0));

`ifdef LA_OVERRIDE_EN
        // 6: LA freeze holds ch0 COUNT and mirrors it on la_data_out
        la_oenb[0] = 1'b0; la_in[0] = 1'b1;
        wr(BASE + 32'h00, 32'd50);
        idle(10);
        check("t6_la_count", 128'(la_data_out[31:0]), 128'(50));
        rd(BASE + 32'h00, v, l);
        check("t6_count_frozen", 128'(v), 128'(50));
        la_oenb[0] = 1'b1; la_in[0] = 1'b0;
`endif

        // 7: reset during a pending write -> no ack, value not written
        wr(BASE + 32'h34, 32'h55);
        rd(BASE + 32'h34, v, l);
        check("t7_pre", 128'(v), 128'(32'h55));
        idle(1);
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h34; dat = 32'h77; sel = 4'hF; rst = 1;
        @(posedge clk); #1;
        check("t7_no_ack", 128'(wbs_ack_o), 128'(0));
        @(negedge clk);
        rst = 0; cyc = 0; stb = 0; we = 0;
        idle(1);
        rd(BASE + 32'h34, v, l);
        check("t7_reload_after_rst", 128'(v), 128'(0));

        // randomized traffic, checked by the per-cycle compare
        for (int t = 0; t < 400; t++) begin
            ch = $urandom_range(0, 5);
            rg = $urandom_range(0, 3);
            a  = BASE + 32'(ch * 16 + rg * 4);
            if ($urandom_range(0, 19) == 0) a = a | 32'h80;
            if ($urandom_range(0, 24) == 0) a = a + 32'h100;
            case (rg)
                0, 1:    d = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 9));
                2:       d = 32'($urandom_range(0, 7));
                default: d = 32'($urandom);
            endcase
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if ($urandom_range(0, 9) == 0) begin
                la_oenb[3:0] = 4'($urandom);
                la_in[3:0]   = 4'($urandom);
            end
            k = $urandom_range(0, 3);
            idle(k);
            xfer(1'($urandom), a, d, s, v, l);
        end

        idle(2);
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wb_multi_timer
`default_nettype wire
